// File: rtl/smart_living_pkg.sv
`default_nettype none
// ---- smart_living_pkg : shared climate states, mode constants, saturating math ----
// ---- Revision 1.0 ----
package smart_living_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEATING = 2'd1,
    COOLING = 2'd2
  } climate_state_t;

  localparam logic AUTO_MODE   = 1'b0;
  localparam logic MANUAL_MODE = 1'b1;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[31:0];
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? 32'd0 : (a - b);
  endfunction

endpackage
`default_nettype wire

// File: rtl/zone_climate_ctrl.sv
`default_nettype none
// ---- zone_climate_ctrl : one zone's occupancy hold, thermostat FSM and load mux ----
// ---- Revision 1.0 ----
module zone_climate_ctrl
  import smart_living_pkg::*;
#(
  parameter int TEMP_W         = 8,
  parameter int HYST           = 2,
  parameter int HOLD_CYCLES    = 1000,
  parameter int MIN_OFF_CYCLES = 200
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_manual,
  input  logic              i_hazard,
  input  logic              i_force_idle,
  input  logic              i_motion,
  input  logic              i_door,
  input  logic [TEMP_W-1:0] i_temp,
  input  logic [TEMP_W-1:0] i_heat_sp,
  input  logic [TEMP_W-1:0] i_cool_sp,
  input  logic              i_man_light,
  input  logic              i_man_fan,
  input  logic              i_man_heat,
  input  logic              i_man_cool,
  output logic              o_light,
  output logic              o_fan,
  output logic              o_heat,
  output logic              o_cool
);

  localparam int OCC_W = $clog2(HOLD_CYCLES + 1);
  localparam int MIN_W = $clog2(MIN_OFF_CYCLES + 1);
  localparam logic [OCC_W-1:0]  c_HOLD = OCC_W'(HOLD_CYCLES);
  localparam logic [MIN_W-1:0]  c_MIN  = MIN_W'(MIN_OFF_CYCLES);
  localparam logic [TEMP_W-1:0] c_TMAX = '1;

  climate_state_t    r_state, w_state_n;
  logic [OCC_W-1:0]  r_occ, w_occ_n;
  logic [MIN_W-1:0]  r_minoff, w_minoff_n;
  logic              w_occupied_n;
  logic              w_light_n, w_fan_n, w_heat_n, w_cool_n;
  logic [TEMP_W-1:0] w_heat_on, w_cool_on;

  // Start thresholds sit HYST beyond the setpoints; stop thresholds are the setpoints.
  assign w_heat_on = TEMP_W'(sat_sub(32'(i_heat_sp), 32'(HYST)));
  assign w_cool_on = TEMP_W'(sat_add(32'(i_cool_sp), 32'(HYST), 32'(c_TMAX)));

  always_comb begin
    w_occ_n = r_occ;
    if (i_motion || i_door)     w_occ_n = c_HOLD;
    else if (r_occ != '0)       w_occ_n = r_occ - OCC_W'(1);
    w_occupied_n = (w_occ_n != '0);

    w_state_n  = r_state;
    w_minoff_n = r_minoff;
    if (i_force_idle) begin
      w_state_n  = IDLE;
      w_minoff_n = c_MIN;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_minoff == '0 && i_temp < w_heat_on)      w_state_n = HEATING;
          else if (r_minoff == '0 && i_temp > w_cool_on) w_state_n = COOLING;
          else if (r_minoff != '0)                       w_minoff_n = r_minoff - MIN_W'(1);
        end
        HEATING: if (i_temp >= i_heat_sp) begin
          w_state_n  = IDLE;
          w_minoff_n = c_MIN;
        end
        COOLING: if (i_temp <= i_cool_sp) begin
          w_state_n  = IDLE;
          w_minoff_n = c_MIN;
        end
        default: begin
          w_state_n  = IDLE;
          w_minoff_n = c_MIN;
        end
      endcase
    end

    if (i_hazard) begin
      w_light_n = 1'b1;
      w_fan_n   = 1'b0;
      w_heat_n  = 1'b0;
      w_cool_n  = 1'b0;
    end else if (i_manual) begin
      w_light_n = i_man_light;
      w_fan_n   = i_man_fan;
      w_heat_n  = i_man_heat & ~i_man_cool;
      w_cool_n  = i_man_cool & ~i_man_heat;
    end else begin
      w_light_n = w_occupied_n;
      w_heat_n  = (w_state_n == HEATING);
      w_cool_n  = (w_state_n == COOLING);
      w_fan_n   = w_occupied_n | (w_state_n != IDLE);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_occ    <= '0;
      r_minoff <= c_MIN;
      o_light  <= 1'b0;
      o_fan    <= 1'b0;
      o_heat   <= 1'b0;
      o_cool   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_occ    <= w_occ_n;
      r_minoff <= w_minoff_n;
      o_light  <= w_light_n;
      o_fan    <= w_fan_n;
      o_heat   <= w_heat_n;
      o_cool   <= w_cool_n;
    end
  end

endmodule
`default_nettype wire

// File: rtl/smart_zone_controller.sv
`default_nettype none
// ---- smart_zone_controller : multi-zone climate/lighting with global hazard handling ----
// ---- Optional macro SMART_ALARM_LATCH_EN latches alarm until acknowledged. Revision 1.0 ----
module smart_zone_controller
  import smart_living_pkg::*;
#(
  parameter int NUM_ZONES      = 4,
  parameter int TEMP_W         = 8,
  parameter int HYST           = 2,
  parameter int HOLD_CYCLES    = 1000,
  parameter int MIN_OFF_CYCLES = 200
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        mode_select,
  input  logic [NUM_ZONES-1:0]        motion_sensor,
  input  logic [NUM_ZONES-1:0]        door_sensor,
  input  logic [NUM_ZONES*TEMP_W-1:0] zone_temp,
  input  logic [TEMP_W-1:0]           heat_setpoint,
  input  logic [TEMP_W-1:0]           cool_setpoint,
  input  logic                        smoke_sensor,
  input  logic                        gas_leak_sensor,
  input  logic                        alarm_ack,
  input  logic [NUM_ZONES-1:0]        manual_light_control,
  input  logic [NUM_ZONES-1:0]        manual_fan_control,
  input  logic [NUM_ZONES-1:0]        manual_heating_control,
  input  logic [NUM_ZONES-1:0]        manual_cooling_control,
  output logic [NUM_ZONES-1:0]        light_output,
  output logic [NUM_ZONES-1:0]        fan_output,
  output logic [NUM_ZONES-1:0]        heating_system_output,
  output logic [NUM_ZONES-1:0]        cooling_system_output,
  output logic                        alarm_output,
  output logic                        emergency_shutdown,
  output logic                        cfg_error
);

  localparam logic [TEMP_W-1:0] c_TMAX = '1;

  logic w_hazard, w_manual, w_cfg_err, w_force_idle;

  assign w_hazard     = smoke_sensor | gas_leak_sensor;
  assign w_manual     = (mode_select == MANUAL_MODE);
  assign w_cfg_err    = TEMP_W'(sat_add(32'(heat_setpoint), 32'(HYST), 32'(c_TMAX))) >= cool_setpoint;
  assign w_force_idle = w_hazard | w_manual | w_cfg_err;

  generate
    for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
      zone_climate_ctrl #(
        .TEMP_W(TEMP_W), .HYST(HYST),
        .HOLD_CYCLES(HOLD_CYCLES), .MIN_OFF_CYCLES(MIN_OFF_CYCLES)
      ) u_zone (
        .i_clk(clock), .i_rst(reset),
        .i_manual(w_manual), .i_hazard(w_hazard), .i_force_idle(w_force_idle),
        .i_motion(motion_sensor[z]), .i_door(door_sensor[z]),
        .i_temp(zone_temp[z*TEMP_W +: TEMP_W]),
        .i_heat_sp(heat_setpoint), .i_cool_sp(cool_setpoint),
        .i_man_light(manual_light_control[z]), .i_man_fan(manual_fan_control[z]),
        .i_man_heat(manual_heating_control[z]), .i_man_cool(manual_cooling_control[z]),
        .o_light(light_output[z]), .o_fan(fan_output[z]),
        .o_heat(heating_system_output[z]), .o_cool(cooling_system_output[z])
      );
    end
  endgenerate

`ifdef SMART_ALARM_LATCH_EN
  logic w_alarm_n;
  // Ack only clears once the hazard is gone; during a hazard it is ignored.
  assign w_alarm_n = w_hazard ? 1'b1 : (alarm_ack ? 1'b0 : alarm_output);
`else
  logic w_alarm_n;
  logic w_unused_ack;
  assign w_unused_ack = alarm_ack;
  assign w_alarm_n    = w_hazard;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      alarm_output       <= 1'b0;
      emergency_shutdown <= 1'b0;
      cfg_error          <= 1'b0;
    end else begin
      alarm_output       <= w_alarm_n;
      emergency_shutdown <= w_hazard;
      cfg_error          <= w_cfg_err;
    end
  end

endmodule
`default_nettype wire
